// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART receiver.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    localparam int DATA_BITS = 8;

    // Clock cycles per oversample tick, rounded to nearest and never below 1.
    function automatic int baud_div(input int clk_freq, input int baud, input int os);
        int d;
        d = (clk_freq + (baud * os) / 2) / (baud * os);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through FIFO with occupancy count; pops are ignored while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q, rdPtr_q;
    logic [AW:0]      count_q, count_d;
    logic             doPush, doPop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign doPop   = pop_i && valid_o;
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign doPush  = push_i && (!full_o || doPop);
    assign data_o  = valid_o ? mem_q[rdPtr_q] : '0;
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with oversampled majority voting, stop-bit checking and a FWFT receive FIFO.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          received,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int DIV   = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] MID   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] WEND  = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] LAST  = OS_W'(OVERSAMPLE - 1);

    rx_state_t        state_q;
    logic             rxMeta_q, rxs_q, rxsPrev_q;
    logic [DIV_W-1:0] divCnt_q;
    logic [OS_W-1:0]  tickCnt_q;
    logic [3:0]       slot_q;
    logic [1:0]       hist_q;
    logic [7:0]       shift_q;
    logic             frameErr_q, overrun_q;
    logic             tick, windowEnd, vote, pushByte, fifoFull;

    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q  <= 1'b1;
            rxs_q     <= 1'b1;
            rxsPrev_q <= 1'b1;
        end else begin
            rxMeta_q  <= received;
            rxs_q     <= rxMeta_q;
            rxsPrev_q <= rxs_q;
        end
    end

    assign tick = (state_q != IDLE) && (divCnt_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE || tick) begin
            divCnt_q <= '0;
        end else begin
            divCnt_q <= divCnt_q + 1'b1;
        end
    end

    // Majority of the three ticks centred on mid-bit; hist_q holds the two earlier samples.
    assign vote      = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
    assign windowEnd = tick && (tickCnt_q == WEND);
    assign pushByte  = (state_q == STOP) && windowEnd && vote;

    // Slot 0 is the start bit, slots 1..8 the data bits; the first window in DATA closes the start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            tickCnt_q  <= '0;
            slot_q     <= '0;
            hist_q     <= 2'b11;
            shift_q    <= '0;
            frameErr_q <= 1'b0;
        end else begin
            frameErr_q <= 1'b0;
            if (tick) begin
                hist_q    <= {hist_q[0], rxs_q};
                tickCnt_q <= (tickCnt_q == LAST) ? '0 : tickCnt_q + 1'b1;
            end
            case (state_q)
                IDLE: begin
                    tickCnt_q <= '0;
                    slot_q    <= '0;
                    if (rxsPrev_q && !rxs_q) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick && tickCnt_q == MID) begin
                        state_q <= rxs_q ? IDLE : DATA;
                        slot_q  <= '0;
                    end
                end
                DATA: begin
                    if (windowEnd) begin
                        if (slot_q != '0) begin
                            shift_q <= {vote, shift_q[7:1]};
                        end
                        if (slot_q == 4'(DATA_BITS)) begin
                            state_q <= STOP;
                        end
                        slot_q <= slot_q + 4'd1;
                    end
                end
                STOP: begin
                    if (windowEnd) begin
                        if (vote) begin
                            state_q <= IDLE;
                        end else begin
                            frameErr_q <= 1'b1;
                            state_q    <= BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (tick && rxs_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= pushByte && fifoFull && !rx_ready;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) rxFifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (pushByte),
        .data_i  (shift_q),
        .pop_i   (rx_ready),
        .data_o  (rx_data),
        .valid_o (rx_valid),
        .full_o  (fifoFull),
        .count_o (fifo_count)
    );

    assign frame_err = frameErr_q;
    assign overrun   = overrun_q;

endmodule
